bus_transfer_controller: RTL and testbench
==========================================

# bus_transfer_controller

Sequencer that moves a value from one `generic_register` to another over the shared tristate `data_bus`. It accepts queued source/destination transfer requests and drives the per-register `oe` and `latch` strobes in a fixed break-before-make order, so at most one register ever drives the bus. It sits beside the register file and runs on the same clock as the registers it controls (the divided clock).

## Interface
- `NUM_REGS`, default 4: number of registers on the bus; range 2..16.
- `QUEUE_DEPTH`, default 2: request queue entries; power of two, at least 2.
- `IDX_W`, derived: `$clog2(NUM_REGS)`. Not user-set.
- `clk`  in  1  register clock; the same net that clocks every controlled register.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  queue can accept; equals not-full, registered.
- `req_src`  in  IDX_W  index of the register to drive the bus.
- `req_dst`  in  IDX_W  index of the register to capture the bus.
- `oe`  out  NUM_REGS  per-register output enable; at most one bit set.
- `latch`  out  NUM_REGS  per-register latch strobe; at most one bit set.
- `busy`  out  1  FSM not in IDLE, or queue not empty.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- **Accept.** A request is accepted on a rising edge where `req_valid && req_ready`.
- **Illegal requests.** A request is illegal if `req_src == req_dst`, `req_src >= NUM_REGS` or `req_dst >= NUM_REGS`.
  - An illegal request is consumed but not queued.
  - `err` is high for the cycle after the accepting edge.
- **Queue.** Legal requests enter the FIFO in order. It has no bypass: an accepted request is visible to the FSM one edge later.
- **FSM states.**
  - IDLE: all strobes 0. If the queue is non-empty, pop the head and go to DRIVE.
  - DRIVE: `oe[src]=1`, all latch bits 0. The bus settles. Next state is LATCH.
  - LATCH: `oe[src]=1`, `latch[dst]=1`. The destination captures on the edge ending this state. Next state is RELEASE.
  - RELEASE: all strobes 0 and `done=1`. This is the bus-turnaround cycle. If the queue is non-empty, pop and go to DRIVE; otherwise go to IDLE.
- **Registered outputs.** `oe`, `latch`, `done`, `err` and `req_ready` are driven from flops only, so there are no glitches on the strobes.
- **Captured indices.** Source and destination are held in state registers from pop until RELEASE. Queue activity cannot alter a transfer in flight.
- **Simultaneous push and pop.** On a non-full queue, the count is unchanged and both operations take effect. When the queue is full, `req_ready` is 0, so no push happens. `req_ready` rises the cycle after a pop.
- **Reset.** Asserting `rst`, including mid-transfer, immediately forces:
  - state to IDLE and the queue to empty;
  - `oe`, `latch`, `done`, `err` and `busy` to 0;
  - `req_ready` to 1.
- **Reset release.** The destination may be left unwritten, which is acceptable; the bus is guaranteed undriven. Operation resumes on the first edge after `rst` deasserts.

## Timing
- The request is accepted at edge E0.
- IDLE pops at E1; `oe[src]` is high from E1.
- LATCH begins at E2, with `oe[src]` and `latch[dst]` high.
- The destination captures at E3. At E3 the FSM enters RELEASE, `done` goes high and all strobes drop.
- Latency: 3 edges from accept to `done`.
- Back-to-back throughput is one transfer per 3 cycles: RELEASE → DRIVE → LATCH → RELEASE.
- `oe` of any register is never high in the same cycle as, or the cycle right after, another register's `oe`. RELEASE separates them.
- `latch[dst]` is high for exactly one cycle per transfer, always inside an `oe[src]` window.
- A rejected request has no effect on strobe timing.

## Structure
- **Shared package `bus_ctrl_pkg`:**
  - state enum (IDLE, DRIVE, LATCH, RELEASE);
  - a request struct with `src` and `dst` of `IDX_W` bits;
  - an `onehot(idx)` decode function.
- **One sub-module, `transfer_queue`:** a synchronous FIFO parameterised on depth and data width.
  - Ports: push, pop, full, empty, head.
  - Reset is asynchronous and active-high, clearing pointers and count.
- The top level holds the FSM, the captured source/destination indices, the illegal-request check and the output flops.

## Test plan
- **Single transfer.** Reset, then one request with src=0, dst=2 (register 0 preloaded 4'hA).
  - `oe=4'b0001` for 2 cycles; `latch=4'b0100` in the second.
  - `done` pulses at E3; register 2 reads 4'hA.
- **Back-to-back and full queue.** Issue 1→3, then 3→0, then 2→1 on consecutive cycles.
  - `req_ready` drops after two queued requests.
  - Three `done` pulses, spaced 3 cycles apart.
  - Transfers complete in issue order with the correct final register values.
- **Illegal requests.** Request src=1, dst=1 → `err` pulses once; no strobe activity; `busy` stays 0. Repeat with `NUM_REGS=3` and src=3 → same response.
- **Reset during LATCH.** Assert `rst` in the middle of a LATCH cycle with a request queued.
  - `oe` and `latch` go to 0 asynchronously, before the next edge.
  - After release: queue empty, `req_ready=1`, no `done`.
- **Bus invariant under random traffic.** Run 1000 random legal and illegal requests with random `req_valid`.
  - Assertions: `$countones(oe)<=1`; `latch` is only high while `oe` is high; no two different `oe` bits set in adjacent cycles.
  - A reference model matches the register contents at the end.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared types for the bus transfer sequencer: FSM states, the queued request record
// and a one-hot index decoder sized for the largest supported register file.
package bus_ctrl_pkg;
    localparam int MAX_REGS  = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LATCH,
        RELEASE
    } state_t;

    // Fields are sized for MAX_REGS; instances zero-extend their narrower indices.
    typedef struct packed {
        logic [MAX_IDX_W-1:0] src;
        logic [MAX_IDX_W-1:0] dst;
    } req_t;

    function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/transfer_queue.sv
// Synchronous FIFO holding pending transfer requests; no bypass, so a push becomes
// visible at the head one edge later. Full and empty are registered flags.
module transfer_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_nxt;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/bus_transfer_controller.sv
// Sequences register-to-register moves over the shared data bus with break-before-make
// oe/latch strobes, so at most one register ever drives the bus.
//
//   state   | meaning
//   IDLE    | no transfer; strobes low; pop head when queue non-empty
//   DRIVE   | oe[src] high, bus settling
//   LATCH   | oe[src] and latch[dst] high; destination captures at the closing edge
//   RELEASE | strobes low, done pulse; bus turnaround before the next DRIVE
module bus_transfer_controller
    import bus_ctrl_pkg::*;
#(
    parameter  int NUM_REGS    = 4,
    parameter  int QUEUE_DEPTH = 2,
    localparam int IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    output logic [NUM_REGS-1:0] oe,
    output logic [NUM_REGS-1:0] latch,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t               state, state_nxt;
    logic [IDX_W-1:0]     src_q, dst_q, src_nxt, dst_nxt;
    logic                 q_full, q_empty, q_pop, q_push;
    logic                 accept, legal;
    req_t                 push_req, head_req;
    logic [$bits(req_t)-1:0] q_head;
    logic [MAX_IDX_W-1:0] src_ext, dst_ext;
    logic [MAX_REGS-1:0]  oe_dec_full, latch_dec_full;
    logic [2*MAX_REGS+$bits(req_t)-1:0] unused_bits;

    assign accept = req_valid && req_ready;
    assign legal  = (req_src != req_dst) && (int'(req_src) < NUM_REGS)
                 && (int'(req_dst) < NUM_REGS);
    assign q_push = accept && legal;
    assign req_ready = !q_full;
    assign busy   = (state != IDLE) || !q_empty;
    assign head_req = req_t'(q_head);

    always_comb begin
        push_req = '0;
        push_req.src[IDX_W-1:0] = req_src;
        push_req.dst[IDX_W-1:0] = req_dst;
    end

    transfer_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     ($bits(req_t))
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (push_req),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    always_comb begin
        state_nxt = state;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        q_pop     = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                if (!q_empty) begin
                    q_pop     = 1'b1;
                    src_nxt   = head_req.src[IDX_W-1:0];
                    dst_nxt   = head_req.dst[IDX_W-1:0];
                    state_nxt = DRIVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DRIVE:   state_nxt = LATCH;
            LATCH:   state_nxt = RELEASE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave flops aligned with it.
    always_comb begin
        src_ext = '0;
        dst_ext = '0;
        src_ext[IDX_W-1:0] = src_nxt;
        dst_ext[IDX_W-1:0] = dst_nxt;
        oe_dec_full    = onehot(src_ext);
        latch_dec_full = onehot(dst_ext);
    end

    assign unused_bits = {oe_dec_full, latch_dec_full, head_req};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            oe    <= '0;
            latch <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            src_q <= src_nxt;
            dst_q <= dst_nxt;
            oe    <= (state_nxt == DRIVE || state_nxt == LATCH)
                     ? oe_dec_full[NUM_REGS-1:0] : '0;
            latch <= (state_nxt == LATCH) ? latch_dec_full[NUM_REGS-1:0] : '0;
            done  <= (state_nxt == RELEASE);
            err   <= accept && !legal;
        end
    end
endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed and random checks of the bus transfer sequencer against a small register-file
// model driven by its oe/latch strobes.
module tb_bus_transfer_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_src = '0, req_dst = '0;
    logic [3:0] oe, latch;
    logic       busy, done, err;

    logic       req3_valid = 1'b0;
    logic       req3_ready;
    logic [1:0] req3_src = '0, req3_dst = '0;
    logic [2:0] oe3, latch3;
    logic       busy3, done3, err3;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [3:0] regs [4];
    logic [3:0] bus;
    logic       load_regs = 1'b1;
    logic       inv_en = 1'b0;
    logic [3:0] prev_oe = '0;

    localparam logic [3:0] T2_OE    [11] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
    localparam logic [3:0] T2_LATCH [11] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    localparam logic       T2_DONE  [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    localparam logic       T2_READY [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    bus_transfer_controller #(.NUM_REGS(4), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .oe(oe), .latch(latch),
        .busy(busy), .done(done), .err(err)
    );

    bus_transfer_controller #(.NUM_REGS(3), .QUEUE_DEPTH(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req3_valid), .req_ready(req3_ready),
        .req_src(req3_src), .req_dst(req3_dst), .oe(oe3), .latch(latch3),
        .busy(busy3), .done(done3), .err(err3)
    );

    always_comb begin
        bus = '0;
        for (int i = 0; i < 4; i++) if (oe[i]) bus = regs[i];
    end

    always @(posedge clk) begin
        if (load_regs) begin
            regs[0] <= 4'hA;
            regs[1] <= 4'h1;
            regs[2] <= 4'h2;
            regs[3] <= 4'h3;
        end else begin
            for (int i = 0; i < 4; i++) if (latch[i]) regs[i] <= bus;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            check_val("inv_oe_onehot", 32'($countones(oe) <= 1), 1);
            check_val("inv_latch_in_oe", 32'((latch == 0) || (oe != 0)), 1);
            check_val("inv_latch_ne_src", 32'(latch & oe), 0);
            check_val("inv_oe_adjacent", 32'((prev_oe == 0) || (oe == 0) || (oe == prev_oe)), 1);
        end
        prev_oe <= oe;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         q_src[$];
        int         q_dst[$];
        logic [3:0] mregs [4];
        logic       quiet;

        // reset values
        #1 rst = 1'b1;
        #2;
        check_val("rst_oe", oe, 0);
        check_val("rst_latch", latch, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", req_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        load_regs = 1'b0;

        // single transfer 0 -> 2
        @(negedge clk);
        req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd2;
        step();
        req_valid = 1'b0;
        check_val("t1_e0_oe", oe, 0);
        check_val("t1_e0_busy", busy, 1);
        step();
        check_val("t1_e1_oe", oe, 4'b0001);
        check_val("t1_e1_latch", latch, 0);
        step();
        check_val("t1_e2_oe", oe, 4'b0001);
        check_val("t1_e2_latch", latch, 4'b0100);
        check_val("t1_e2_done", done, 0);
        step();
        check_val("t1_e3_oe", oe, 0);
        check_val("t1_e3_latch", latch, 0);
        check_val("t1_e3_done", done, 1);
        check_val("t1_reg2", regs[2], 4'hA);
        step();
        check_val("t1_e4_done", done, 0);
        check_val("t1_e4_busy", busy, 0);

        // back-to-back 1->3, 3->0, 2->1
        @(negedge clk);
        req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd3;
        for (int k = 0; k < 11; k++) begin
            step();
            check_val($sformatf("t2_oe_%0d", k), oe, T2_OE[k]);
            check_val($sformatf("t2_latch_%0d", k), latch, T2_LATCH[k]);
            check_val($sformatf("t2_done_%0d", k), done, T2_DONE[k]);
            check_val($sformatf("t2_ready_%0d", k), req_ready, T2_READY[k]);
            case (k)
                0: begin req_src = 2'd3; req_dst = 2'd0; end
                1: begin req_src = 2'd2; req_dst = 2'd1; end
                default: req_valid = 1'b0;
            endcase
        end
        check_val("t2_reg0", regs[0], 4'h1);
        check_val("t2_reg1", regs[1], 4'hA);
        check_val("t2_reg2", regs[2], 4'hA);
        check_val("t2_reg3", regs[3], 4'h1);

        // illegal requests: src==dst on 4-reg instance, src out of range on 3-reg instance
        @(negedge clk);
        req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd1;
        req3_valid = 1'b1; req3_src = 2'd3; req3_dst = 2'd0;
        step();
        req_valid = 1'b0; req3_valid = 1'b0;
        check_val("t3_err", err, 1);
        check_val("t3_busy", busy, 0);
        check_val("t3_err3", err3, 1);
        check_val("t3_busy3", busy3, 0);
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (oe != 0 || latch != 0 || busy || done || err) quiet = 1'b0;
            if (oe3 != 0 || latch3 != 0 || busy3 || done3 || err3) quiet = 1'b0;
        end
        check_val("t3_quiet_after", quiet, 1);

        // reset during LATCH with a second request queued
        @(negedge clk);
        req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd1;
        step();
        req_src = 2'd2; req_dst = 2'd3;
        step();
        req_valid = 1'b0;
        step();
        check_val("t4_latch_before", latch, 4'b0010);
        check_val("t4_oe_before", oe, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check_val("t4_oe_async", oe, 0);
        check_val("t4_latch_async", latch, 0);
        check_val("t4_busy_async", busy, 0);
        check_val("t4_ready_async", req_ready, 1);
        #1 rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (oe != 0 || latch != 0 || busy || done || !req_ready) quiet = 1'b0;
        end
        check_val("t4_quiet_after", quiet, 1);

        // random traffic with bus invariants and end-state register model
        for (int i = 0; i < 4; i++) mregs[i] = regs[i];
        inv_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_src   = 2'($urandom_range(0, 3));
            req_dst   = 2'($urandom_range(0, 3));
            if (req_valid && req_ready && req_src != req_dst) begin
                q_src.push_back(int'(req_src));
                q_dst.push_back(int'(req_dst));
            end
            step();
        end
        req_valid = 1'b0;
        for (int c = 0; c < 40 && busy; c++) step();
        check_val("t5_drain", busy, 0);
        step();
        inv_en = 1'b0;
        foreach (q_src[j]) mregs[q_dst[j]] = mregs[q_src[j]];
        for (int i = 0; i < 4; i++) check_val($sformatf("t5_reg%0d", i), regs[i], mregs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
